// File: rtl/proc_engine_out.sv
// proc_engine_out
// Takes one full accumulator beat (COLS columns x ROWS words). Only the
// columns selected by the kernel-width stride ("keep mask") are passed on,
// one column per output handshake, in ascending column order.
//
// Handshake rule, on both ports: a transfer happens on a rising clk edge
// where valid and ready are both 1. Once m_valid is raised, m_data, m_user
// and m_last hold until the word group is taken. s_ready does not depend on
// s_valid.
//
// s_user layout: kw2 occupies bits [KW2_W-1:0] and is_config is bit KW2_W,
// where KW2_W = $clog2(KW_MAX+1). Any higher bits pass through to m_user
// unchanged.
//
// Optional feature: define PROC_ENGINE_OUT_COL_IDX_EN to add the m_col output.
// m_col carries the source column index of the word group on m_data.
module proc_engine_out #(
  parameter int COLS        = 8,
  parameter int ROWS        = 4,
  parameter int Y_BITS      = 32,
  parameter int KW_MAX      = 7,
  parameter int TUSER_WIDTH = 8
) (
  input  logic                                   clk,
  input  logic                                   resetn,
  input  logic                                   s_valid,
  output logic                                   s_ready,
  input  logic                                   s_last,
  input  logic [COLS-1:0][ROWS-1:0][Y_BITS-1:0]  s_data,
  input  logic [TUSER_WIDTH-1:0]                 s_user,
  output logic                                   m_valid,
  input  logic                                   m_ready,
  output logic                                   m_last,
  output logic [ROWS-1:0][Y_BITS-1:0]            m_data,
  output logic [TUSER_WIDTH-1:0]                 m_user
`ifdef PROC_ENGINE_OUT_COL_IDX_EN
  ,
  output logic [$clog2(COLS)-1:0]                m_col
`endif
);

  localparam int COL_W  = $clog2(COLS);
  localparam int KW2_W  = $clog2(KW_MAX + 1);
  localparam int KW2_HI = KW_MAX / 2;
  localparam logic [COLS-1:0] MASK_ONE = {{(COLS-1){1'b0}}, 1'b1};

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Columns kept for a kernel half-width k: every (2k+1)-th column,
  // counting from 1. Only ever called with a constant k.
  function automatic logic [COLS-1:0] keep_mask(input int k);
    logic [COLS-1:0] m;
    m = '0;
    for (int c = 0; c < COLS; c++) begin
      if (((c + 1) % (2 * k + 1)) == 0) m[c] = 1'b1;
    end
    return m;
  endfunction

  // Index of the lowest set bit. Returns 0 for an all-zero mask.
  function automatic logic [COL_W-1:0] low_idx(input logic [COLS-1:0] m);
    logic [COL_W-1:0] idx;
    idx = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (m[c]) idx = COL_W'(c);
    end
    return idx;
  endfunction

  // State and control registers, cleared by reset.
  state_t                           state_q, state_d;
  logic [COLS-1:0]                  mask_q, mask_d;
  logic                             rdy_en_q, rdy_en_d;

  // Beat payload registers, not reset. They are only observed while m_valid=1.
  logic [COLS-1:0][ROWS-1:0][Y_BITS-1:0] data_q, data_d;
  logic [TUSER_WIDTH-1:0]           user_q, user_d;
  logic                             last_q, last_d;

  // Combinational helpers.
  logic [KW2_W-1:0]                 kw2_in;
  logic                             cfg_in;
  logic [COLS-1:0]                  in_mask;
  logic [COLS-1:0]                  mask_rest;
  logic [COL_W-1:0]                 cur_col;
  logic                             is_final;
  logic                             load;

  assign kw2_in = s_user[KW2_W-1:0];
  assign cfg_in = s_user[KW2_W];

  // Keep mask for the beat at the input. The mask is all zero for a config
  // beat or an out-of-range kw2, so such a beat is dropped.
  always_comb begin
    in_mask = '0;
    if (!cfg_in) begin
      for (int k = 0; k <= KW2_HI; k++) begin
        if (int'(kw2_in) == k) in_mask = keep_mask(k);
      end
    end
  end

  // Next state and outputs. mask_q holds the columns not yet emitted,
  // including the one now on m_data. The lowest set bit is the current column.
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    rdy_en_d  = 1'b1;
    load      = 1'b0;
    cur_col   = low_idx(mask_q);
    mask_rest = mask_q & (mask_q - MASK_ONE);
    is_final  = (mask_rest == '0);
    m_valid   = (state_q == SHIFT);
    m_last    = (state_q == SHIFT) && is_final && last_q;
    s_ready   = 1'b0;

    case (state_q)
      IDLE: begin
        s_ready = rdy_en_q;
        if (s_valid && rdy_en_q && (in_mask != '0)) begin
          load    = 1'b1;
          mask_d  = in_mask;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // A new beat may enter only while the last kept column leaves.
        // The next beat then follows with no bubble.
        s_ready = rdy_en_q && is_final && m_ready;
        if (m_ready) begin
          if (!is_final) begin
            mask_d = mask_rest;
          end else if (s_valid && rdy_en_q && (in_mask != '0)) begin
            load   = 1'b1;
            mask_d = in_mask;
          end else begin
            mask_d  = '0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        mask_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Payload capture on an accepted beat that has at least one kept column.
  always_comb begin
    data_d = data_q;
    user_d = user_q;
    last_d = last_q;
    if (load) begin
      data_d = s_data;
      user_d = s_user;
      last_d = s_last;
    end
  end

  // Control registers. Reset drops any partly emitted beat.
  // rdy_en_q keeps s_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      mask_q   <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      rdy_en_q <= rdy_en_d;
    end
  end

  // Payload registers. Reset is not needed because they are only read under m_valid.
  always_ff @(posedge clk) begin
    data_q <= data_d;
    user_q <= user_d;
    last_q <= last_d;
  end

  assign m_data = data_q[cur_col];
  assign m_user = user_q;

`ifdef PROC_ENGINE_OUT_COL_IDX_EN
  logic [COL_W-1:0] col_q, col_d;

  // Column index of the next word group. It follows mask_d, so it is
  // stable under backpressure.
  always_comb begin
    col_d = low_idx(mask_d);
  end

  // Column index register, cleared by reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) col_q <= '0;
    else         col_q <= col_d;
  end

  assign m_col = col_q;
`endif

endmodule

// File: tb/tb_proc_engine_out.sv
// Bench for proc_engine_out (COLS=8, ROWS=4, Y_BITS=32, KW_MAX=7).
// The directed steps run first, then a randomized stream with random
// backpressure. The reference model is a queue of the expected output words,
// built from the stride rule.
`timescale 1ns/1ps
module tb_proc_engine_out;

  localparam int COLS   = 8;
  localparam int ROWS   = 4;
  localparam int YB     = 32;
  localparam int KW_MAX = 7;
  localparam int UW     = 8;
  localparam int EW     = 1 + UW + ROWS * YB;

  typedef logic [ROWS-1:0][YB-1:0]            col_t;
  typedef logic [COLS-1:0][ROWS-1:0][YB-1:0]  beat_t;

  // Clock and reset
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  logic          s_valid;
  logic          s_ready;
  logic          s_last;
  beat_t         s_data;
  logic [UW-1:0] s_user;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  col_t          m_data;
  logic [UW-1:0] m_user;
`ifdef PROC_ENGINE_OUT_COL_IDX_EN
  logic [$clog2(COLS)-1:0] m_col;
`endif

  logic bp_en;
  logic bp_rdy;
  logic dir_rdy;
  assign m_ready = bp_en ? bp_rdy : dir_rdy;

  proc_engine_out #(
    .COLS(COLS), .ROWS(ROWS), .Y_BITS(YB), .KW_MAX(KW_MAX), .TUSER_WIDTH(UW)
  ) dut (
    .clk(clk), .resetn(resetn),
    .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last),
    .s_data(s_data), .s_user(s_user),
    .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .m_data(m_data), .m_user(m_user)
`ifdef PROC_ENGINE_OUT_COL_IDX_EN
    , .m_col(m_col)
`endif
  );

  // Scoreboard state
  logic [EW-1:0] exp_q[$];
  int            exp_col_q[$];
  int            n_checks = 0;
  int            n_pass   = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model: the kept columns are every (2*kw2+1)-th column,
  // counting from 1. A config beat or kw2 > KW_MAX/2 produces no output.
  function automatic void model_beat(input beat_t d, input logic [UW-1:0] u, input logic l);
    int kw2;
    int period;
    int kept[$];
    kw2 = int'(u[2:0]);
    if (u[3] || kw2 > KW_MAX / 2) return;
    period = 2 * kw2 + 1;
    for (int c = 0; c < COLS; c++) begin
      if ((c + 1) % period == 0) kept.push_back(c);
    end
    foreach (kept[i]) begin
      exp_q.push_back({l && (i == kept.size() - 1), u, d[kept[i]]});
      exp_col_q.push_back(kept[i]);
    end
  endfunction

  function automatic beat_t rand_beat();
    beat_t d;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        d[c][r] = $urandom();
    return d;
  endfunction

  function automatic logic [UW-1:0] mk_user(input int kw2, input logic cfg);
    logic [UW-1:0] u;
    u      = UW'($urandom());
    u[2:0] = kw2[2:0];
    u[3]   = cfg;
    return u;
  endfunction

  // Driver. It is entered and left at posedge+1. s_ready is sampled at the
  // negedge, so the handshake edge is known without a race.
  task automatic send_beat(input beat_t d, input logic [UW-1:0] u, input logic l, output int waits);
    logic hs;
    hs    = 1'b0;
    waits = 0;
    s_valid = 1'b1; s_data = d; s_user = u; s_last = l;
    while (!hs && waits < 200) begin
      @(negedge clk);
      hs = s_ready;
      @(posedge clk);
      #1;
      waits++;
    end
    chk("send_handshake", hs, 1'b1);
    s_valid = 1'b0;
    if (hs) model_beat(d, u, l);
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || m_valid) && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic watch_streak(input int n);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!m_valid && k < 20);
    chk("streak_start", m_valid, 1'b1);
    for (int i = 1; i < n; i++) begin
      @(negedge clk);
      chk("streak_valid", m_valid, 1'b1);
    end
    @(negedge clk);
    chk("streak_end", m_valid, 1'b0);
  endtask

  // Random backpressure source, updated just after each rising edge.
  initial begin
    bp_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bp_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops the expected queue on each output transfer and checks that
  // the outputs hold while stalled.
  logic          prev_stall = 1'b0;
  logic [EW-1:0] prev_word;
  always @(negedge clk) begin
    if (!resetn) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", m_valid, 1'b1);
        chk("hold_word", {m_last, m_user, m_data}, prev_word);
      end
      if (m_valid && m_ready) begin
        chk("out_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          logic [EW-1:0] w;
          int            c;
          w = exp_q.pop_front();
          c = exp_col_q.pop_front();
          chk("out_word", {m_last, m_user, m_data}, w);
`ifdef PROC_ENGINE_OUT_COL_IDX_EN
          chk("out_col", m_col, c);
`endif
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_word  = {m_last, m_user, m_data};
    end
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  beat_t         d;
  logic [UW-1:0] u;
  int            w;

  // Directed sequence, then the random stream.
  initial begin
    resetn  = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    s_user  = '0;
    dir_rdy = 1'b1;
    bp_en   = 1'b0;

    // Outputs during reset, then s_ready after release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", s_ready, 1'b0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_last", m_last, 1'b0);
    @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rel_s_ready", s_ready, 1'b1);
    chk("rel_m_valid", m_valid, 1'b0);
    @(posedge clk);
    #1;

    // kw2=0, last beat: 8 groups back-to-back, m_last only on column 7.
    d = rand_beat();
    u = mk_user(0, 1'b0);
    send_beat(d, u, 1'b1, w);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("kw0_valid", m_valid, 1'b1);
      chk("kw0_last", m_last, (i == 7));
    end
    @(negedge clk);
    chk("kw0_idle", m_valid, 1'b0);
    @(posedge clk);
    #1;

    // kw2=1: only columns 2 and 5, m_last on 5.
    d = rand_beat();
    u = mk_user(1, 1'b0);
    send_beat(d, u, 1'b1, w);
    @(negedge clk);
    chk("kw1_c2_data", m_data, d[2]);
    chk("kw1_c2_last", m_last, 1'b0);
    @(negedge clk);
    chk("kw1_c5_data", m_data, d[5]);
    chk("kw1_c5_last", m_last, 1'b1);
    @(negedge clk);
    chk("kw1_idle", m_valid, 1'b0);
    @(posedge clk);
    #1;

    // Config beat is dropped. The next beat is accepted on the following cycle.
    d = rand_beat();
    u = mk_user(0, 1'b1);
    send_beat(d, u, 1'b1, w);
    d = rand_beat();
    u = mk_user(2, 1'b0);
    send_beat(d, u, 1'b0, w);
    chk("cfg_next_accept", w, 1);
    @(negedge clk);
    chk("kw2_c4_data", m_data, d[4]);
    chk("kw2_c4_user", m_user, u);
    @(negedge clk);
    chk("kw2_idle", m_valid, 1'b0);
    @(posedge clk);
    #1;

    // An out-of-range kw2 produces no output.
    d = rand_beat();
    u = mk_user(5, 1'b0);
    send_beat(d, u, 1'b1, w);
    @(negedge clk);
    chk("kw5_no_valid", m_valid, 1'b0);
    chk("kw5_s_ready", s_ready, 1'b1);
    @(posedge clk);
    #1;

    // Stall for 5 cycles on column 3.
    d = rand_beat();
    u = mk_user(0, 1'b0);
    send_beat(d, u, 1'b1, w);
    repeat (3) @(posedge clk);
    #1 dir_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", m_valid, 1'b1);
      chk("bp_data", m_data, d[3]);
      chk("bp_user", m_user, u);
    end
    @(posedge clk);
    #1 dir_rdy = 1'b1;
    wait_drain(50);

    // Two kw2=1 beats back-to-back: four groups on consecutive cycles.
    fork
      begin
        beat_t         da, db;
        logic [UW-1:0] ua, ub;
        int            wa;
        da = rand_beat(); ua = mk_user(1, 1'b0);
        db = rand_beat(); ub = mk_user(1, 1'b0);
        send_beat(da, ua, 1'b0, wa);
        send_beat(db, ub, 1'b1, wa);
      end
      watch_streak(4);
    join
    @(posedge clk);
    #1;
    wait_drain(50);

    // Reset while column 4 is on the output. The rest of the beat is discarded.
    d = rand_beat();
    u = mk_user(0, 1'b0);
    send_beat(d, u, 1'b1, w);
    repeat (4) @(posedge clk);
    #2;
    chk("mid_c4_data", m_data, d[4]);
    resetn = 1'b0;
    #1;
    chk("mid_rst_valid", m_valid, 1'b0);
    chk("mid_rst_s_ready", s_ready, 1'b0);
    exp_q.delete();
    exp_col_q.delete();
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rel_s_ready", s_ready, 1'b1);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        seen = seen | m_valid;
      end
      chk("mid_no_leftover", seen, 1'b0);
    end
    @(posedge clk);
    #1;

    // Random beats with random backpressure.
    bp_en = 1'b1;
    for (int n = 0; n < 60; n++) begin
      d = rand_beat();
      u = mk_user($urandom_range(0, 7), ($urandom_range(0, 7) == 0));
      send_beat(d, u, logic'($urandom_range(0, 1)), w);
    end
    wait_drain(2000);
    bp_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/proc_engine_out.md
PROC_ENGINE_OUT -- requirements
Module: proc_engine_out

Interface
REQ-001 SHALL have parameter COLS, default `COLS: number of accumulator columns per input beat.
REQ-002 SHALL have parameter ROWS, default `ROWS: number of output words per column.
REQ-003 SHALL have parameter Y_BITS, default `Y_BITS: width of one accumulated word.
REQ-004 SHALL have parameter KW_MAX, default `KW_MAX: maximum kernel width, so kw2 ranges over 0..KW_MAX/2.
REQ-005 SHALL have parameter TUSER_WIDTH, default `TUSER_WIDTH: width of tuser_st.
REQ-006 SHALL have port clk, input, 1 bit: the only clock.
REQ-007 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port s_valid, input, 1 bit: input beat valid.
REQ-009 SHALL have port s_ready, output, 1 bit: input beat accepted.
REQ-010 SHALL have port s_last, input, 1 bit: last beat of the packet.
REQ-011 SHALL have port s_data, input, [COLS][ROWS][Y_BITS]: full accumulator array from the processing engine.
REQ-012 SHALL have port s_user, input, tuser_st: per-beat control; fields kw2 and is_config are used.
REQ-013 SHALL have port m_valid, input/output direction output, 1 bit: output word group valid.
REQ-014 SHALL have port m_ready, input, 1 bit: downstream accepts the word group.
REQ-015 SHALL have port m_last, output, 1 bit: last word group of the packet.
REQ-016 SHALL have port m_data, output, [ROWS][Y_BITS]: one column of sums.
REQ-017 SHALL have port m_user, output, tuser_st: s_user of the beat being emitted.

Function
REQ-018 SHALL form the keep mask on input handshake: column c is kept iff (c+1) mod (2*kw2+1) == 0, for c in 0..COLS-1.
REQ-019 SHALL use an all-zero keep mask when is_config=1 or kw2 > KW_MAX/2.
REQ-020 SHALL have FSM states IDLE and SHIFT; IDLE asserts s_ready=1 and m_valid=0.
REQ-021 SHALL, on handshake with a zero mask, drop the beat without producing output, stay in IDLE, and keep s_ready=1 in the next cycle.
REQ-022 SHALL, on handshake with a nonzero mask, register s_data, s_user, s_last and the mask, then enter SHIFT.
REQ-023 SHALL assert m_valid in the cycle after the input handshake (latency 1).
REQ-024 SHALL, in SHIFT, present kept columns in ascending index order, one column per m_valid&&m_ready handshake.
REQ-025 SHALL hold m_data, m_user and m_last stable while m_valid=1 and m_ready=0.
REQ-026 SHALL assert m_last only on the final kept column of a beat registered with s_last=1.
REQ-027 SHALL assert s_ready in SHIFT only when the final kept column is handshaking (s_ready = IDLE || (final && m_ready)).
REQ-028 SHALL, when a new beat is accepted in that same cycle, go straight to the new beat's first kept column with no bubble; otherwise return to IDLE.
REQ-029 SHALL select the next kept column by priority-encoding the remaining mask and clearing each emitted bit.
REQ-030 SHALL reach at most one m_valid cycle per cycle, i.e. the mask holds at most COLS bits.

Reset
REQ-031 SHALL, while resetn=0, force state to IDLE and m_valid=0, m_last=0, clear the mask, and drive s_ready=0.
REQ-032 SHALL drive s_ready=1 from the first clk edge after resetn is released.
REQ-033 SHALL discard without output a beat that is partially emitted when reset is asserted.
REQ-034 SHALL leave the data registers m_data and m_user non-reset, with value don't-care while m_valid=0.

Configuration
REQ-035 SHALL, when PROC_ENGINE_OUT_COL_IDX_EN is defined, add output port m_col of width $clog2(COLS) carrying the source column index of m_data, reset to 0 and held stable under backpressure.
REQ-036 SHALL, when PROC_ENGINE_OUT_COL_IDX_EN is undefined, have no m_col port and no column-index register.

Verification (COLS=8, ROWS=4, Y_BITS=32)
REQ-037 SHALL cover: kw2=0, s_last=1, m_ready=1 -> 8 groups on consecutive cycles for cols 0..7, with m_last only on col 7.
REQ-038 SHALL cover: kw2=1 -> only cols 2 and 5 are emitted; cols 6 and 7 are dropped; m_last is on col 5.
REQ-039 SHALL cover: is_config=1 beat -> m_valid never rises, and a second beat is accepted on the next cycle.
REQ-040 SHALL cover: kw2=0 with m_ready=0 for 5 cycles at col 3 -> m_data/m_user stay equal to col 3, and the output sequence is complete with none lost or duplicated.
REQ-041 SHALL cover: two kw2=1 beats back-to-back -> outputs cols 2, 5, 2, 5 on 4 consecutive cycles.
REQ-042 SHALL cover: resetn=0 during col 4 of a kw2=0 beat -> m_valid=0 immediately; after release s_ready=1 and the remaining columns are never emitted.
